// File: rtl/wta_knn_ranker_if.sv
// Control, PWM and result bundle for wta_knn_ranker.
// The master drives window setup and the PWM pins; the slave is the ranker.
interface wta_knn_ranker_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 12,
  parameter int K_W   = 3
);
  logic                  i_start;
  logic [K_W-1:0]        i_k;
  logic                  i_mode;
  logic [N_CH-1:0]       i_en;
  logic [CNT_W-1:0]      i_timeout;
  logic [N_CH-1:0]       i_pwm;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_timeout;
  logic [N_CH-1:0]       o_nn;
  logic [N_CH-1:0]       o_knn;
  logic [N_CH*CNT_W-1:0] o_ts;
  logic [N_CH-1:0]       o_fin;

  modport master (
    output i_start, i_k, i_mode, i_en, i_timeout, i_pwm,
    input  o_busy, o_done, o_timeout, o_nn, o_knn, o_ts, o_fin
  );

  modport slave (
    input  i_start, i_k, i_mode, i_en, i_timeout, i_pwm,
    output o_busy, o_done, o_timeout, o_nn, o_knn, o_ts, o_fin
  );
endinterface

// File: rtl/wta_knn_ranker.sv
// Winner-take-all / k-NN ranker: timestamps the first qualifying PWM edge per
// channel inside a window and ranks arrivals, with simultaneous finishers sharing a rank.
module wta_knn_ranker #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 12,
  parameter int K_W   = 3
) (
  input logic            clk,
  input logic            rst,
  wta_knn_ranker_if.slave bus
);
  localparam int RANK_W = $clog2(N_CH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEASURE = 2'd1, S_DONE = 2'd2} state_t;

  function automatic logic [RANK_W-1:0] popcount(input logic [N_CH-1:0] v);
    logic [RANK_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_CH; i++) cnt = cnt + RANK_W'(v[i]);
    return cnt;
  endfunction

  state_t                r_state, w_state_nxt;
  logic                  r_busy, r_done, w_busy_nxt, w_done_nxt;
  logic [N_CH-1:0]       r_sync1, r_sync2, r_prev;
  logic [K_W-1:0]        r_k;
  logic                  r_mode;
  logic [N_CH-1:0]       r_en;
  logic [CNT_W-1:0]      r_tmo, r_timer;
  logic [RANK_W-1:0]     r_n_fin;
  logic [RANK_W-1:0]     r_rank [N_CH];
  logic [N_CH-1:0]       r_fin, r_nn, r_knn;
  logic [N_CH*CNT_W-1:0] r_ts;
  logic                  r_timeout;

  logic [N_CH-1:0]       w_edge, w_fin_now, w_fin_nxt, w_nn_nxt, w_knn_nxt;
  logic [RANK_W-1:0]     w_rank_nxt [N_CH];
  logic                  w_all_fin, w_tmo_hit, w_end;

  // Edge detection, finisher selection, termination and next-cycle rank masks
  always_comb begin
    w_edge    = r_mode ? (r_sync2 & ~r_prev) : (~r_sync2 & r_prev);
    if (r_state == S_MEASURE) begin
      w_fin_now = r_en & ~r_fin & w_edge;
    end else begin
      w_fin_now = '0;
    end
    w_fin_nxt = r_fin | w_fin_now;
    w_all_fin = ((w_fin_nxt & r_en) == r_en);
    w_tmo_hit = (r_timer == r_tmo);
    w_end     = (r_state == S_MEASURE) && (w_all_fin || w_tmo_hit);
    w_nn_nxt  = '0;
    w_knn_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_rank_nxt[i] = w_fin_now[i] ? r_n_fin : r_rank[i];
      w_nn_nxt[i]   = w_fin_nxt[i] && (w_rank_nxt[i] == '0);
      w_knn_nxt[i]  = w_fin_nxt[i] && (32'(w_rank_nxt[i]) < 32'(r_k));
    end
  end

  // FSM state register together with the registered busy/done flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) w_state_nxt = S_MEASURE;
        else             w_state_nxt = S_IDLE;
      end
      S_MEASURE: begin
        if (w_end) w_state_nxt = S_DONE;
        else       w_state_nxt = S_MEASURE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the next state so they register alongside it
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      S_MEASURE: w_busy_nxt = 1'b1;
      S_DONE:    w_done_nxt = 1'b1;
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // Synchroniser, window setup latch, timer and per-channel result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_k       <= '0;
      r_mode    <= 1'b0;
      r_en      <= '0;
      r_tmo     <= '0;
      r_timer   <= '0;
      r_n_fin   <= '0;
      r_fin     <= '0;
      r_nn      <= '0;
      r_knn     <= '0;
      r_ts      <= {(N_CH*CNT_W){1'b1}};
      r_timeout <= 1'b0;
      for (int i = 0; i < N_CH; i++) r_rank[i] <= '0;
    end else begin
      r_sync1 <= bus.i_pwm;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_k       <= bus.i_k;
            r_mode    <= bus.i_mode;
            r_en      <= bus.i_en;
            r_tmo     <= bus.i_timeout;
            r_timer   <= '0;
            r_n_fin   <= '0;
            r_fin     <= '0;
            r_nn      <= '0;
            r_knn     <= '0;
            r_ts      <= {(N_CH*CNT_W){1'b1}};
            r_timeout <= 1'b0;
            for (int i = 0; i < N_CH; i++) r_rank[i] <= '0;
          end
        end
        S_MEASURE: begin
          if (r_timer != {CNT_W{1'b1}}) r_timer <= r_timer + CNT_W'(1);
          r_fin   <= w_fin_nxt;
          r_nn    <= w_nn_nxt;
          r_knn   <= w_knn_nxt;
          r_n_fin <= r_n_fin + popcount(w_fin_now);
          for (int i = 0; i < N_CH; i++) begin
            r_rank[i] <= w_rank_nxt[i];
            if (w_fin_now[i]) r_ts[i*CNT_W +: CNT_W] <= r_timer;
          end
          // A window that completes on its last timed cycle is not a timeout
          if (w_tmo_hit && !w_all_fin) r_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_timeout = r_timeout;
  assign bus.o_nn      = r_nn;
  assign bus.o_knn     = r_knn;
  assign bus.o_ts      = r_ts;
  assign bus.o_fin     = r_fin;
endmodule
